// File: rtl/count_add_pkg.sv
// Shared constants and helpers for the count/add pipeline.
package count_add_pkg;
  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Increment a width-bit counter held in the low bits of value; at the top
  // value it either wraps to 0 or stays put, depending on mode.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width, input int mode);
    logic [31:0] mx;
    mx = (32'd1 << width) - 32'd1;
    if (value >= mx) return (mode == CNT_SAT) ? mx : 32'd0;
    return value + 32'd1;
  endfunction
endpackage

// File: rtl/count_add_pipe_if.sv
// Beat bus for count_add_pipe: input handshake, output handshake, clear and count.
interface count_add_pipe_if #(
  parameter int DW = 4,
  parameter int CW = 3
);
  logic          clr;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_i;
  logic          valid_o;
  logic          ready_i;
  logic [DW-1:0] data_o;
  logic [CW-1:0] count_o;

  modport master (output clr, valid_i, data_i, ready_i,
                  input  ready_o, valid_o, data_o, count_o);
  modport slave  (input  clr, valid_i, data_i, ready_i,
                  output ready_o, valid_o, data_o, count_o);
endinterface

// File: rtl/count_add_stage.sv
// One register slice of the pipeline: valid/data pair with pass-through ready.
module count_add_stage #(
  parameter int DW         = 4,
  parameter bit RESET_DATA = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vld_i,
  input  logic [DW-1:0] dat_i,
  input  logic          rdy_i,
  output logic          vld_o,
  output logic [DW-1:0] dat_o,
  output logic          rdy_o
);
  logic          vld_q;
  logic [DW-1:0] dat_q;

  // Slot can take a beat when empty or when its occupant leaves this cycle.
  assign rdy_o = rdy_i || !vld_q;
  assign vld_o = vld_q;
  assign dat_o = dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     vld_q <= 1'b0;
    else if (rdy_o) vld_q <= vld_i;
  end

  generate
    if (RESET_DATA) begin : g_dat_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              dat_q <= '0;
        else if (rdy_o && vld_i) dat_q <= dat_i;
      end
    end else begin : g_dat_nrst
      always_ff @(posedge clk) begin
        if (rdy_o && vld_i) dat_q <= dat_i;
      end
    end
  endgenerate
endmodule

// File: rtl/count_add_pipe.sv
// Beat counter plus adder feeding a STAGES-deep valid/ready register pipeline.
module count_add_pipe
  import count_add_pkg::*;
#(
  parameter int DW         = 4,
  parameter int CW         = 3,
  parameter int STAGES     = 2,
  parameter int SAT        = CNT_WRAP,
  parameter bit RESET_DATA = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  count_add_pipe_if.slave bus
);
  logic [STAGES:0]         vld_pipe;
  logic [STAGES:0]         rdy_pipe;
  logic [STAGES:0][DW-1:0] dat_pipe;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DW+CW-1:0]        cnt_wide;
  logic                    accept;

  assign bus.ready_o = rdy_pipe[0] && rst_n;
  assign accept      = bus.valid_i && bus.ready_o;

  // Zero-extend or truncate the count to DW; the sum uses the pre-increment value.
  assign cnt_wide    = {{DW{1'b0}}, cnt_q};
  assign vld_pipe[0] = bus.valid_i;
  assign dat_pipe[0] = bus.data_i + cnt_wide[DW-1:0];
  assign rdy_pipe[STAGES] = bus.ready_i;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr)     cnt_d = '0;
    else if (accept) cnt_d = CW'(sat_inc(32'(cnt_q), CW, SAT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      count_add_stage #(.DW(DW), .RESET_DATA(RESET_DATA)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (vld_pipe[k]),
        .dat_i (dat_pipe[k]),
        .rdy_i (rdy_pipe[k+1]),
        .vld_o (vld_pipe[k+1]),
        .dat_o (dat_pipe[k+1]),
        .rdy_o (rdy_pipe[k])
      );
    end
  endgenerate

  assign bus.valid_o = vld_pipe[STAGES];
  assign bus.data_o  = dat_pipe[STAGES];
  assign bus.count_o = cnt_q;
endmodule

// File: tb/tb_count_add_pipe.sv
// Scoreboard bench: a wrap/no-data-reset unit and a saturate/data-reset unit driven in lockstep.
module tb_count_add_pipe;
  localparam int DW = 4, CW = 3, ST = 2;
  localparam int DMOD = 1 << DW, CMAX = (1 << CW) - 1;

  typedef struct { int d; int acc; } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  count_add_pipe_if #(.DW(DW), .CW(CW)) ifa ();
  count_add_pipe_if #(.DW(DW), .CW(CW)) ifb ();

  count_add_pipe #(.DW(DW), .CW(CW), .STAGES(ST), .SAT(0), .RESET_DATA(1'b0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  count_add_pipe #(.DW(DW), .CW(CW), .STAGES(ST), .SAT(1), .RESET_DATA(1'b1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  logic [1:0]         vo, ro;
  logic [1:0][DW-1:0] dout;
  logic [1:0][CW-1:0] cout;
  assign vo   = {ifb.valid_o, ifa.valid_o};
  assign ro   = {ifb.ready_o, ifa.ready_o};
  assign dout = {ifb.data_o,  ifa.data_o};
  assign cout = {ifb.count_o, ifa.count_o};

  int   total = 0, bad = 0, cyc = 0;
  exp_t q [2][$];
  int   cnt [2];

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Reference: pipe occupancy is the number of accepted-but-undelivered beats;
  // the oldest beat reaches the output ST cycles after its acceptance cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin q[u].delete(); cnt[u] = 0; end
    end else begin
      for (int u = 0; u < 2; u++) begin
        exp_t e;
        int   ev;
        chk(u ? "b_count" : "a_count", int'(cout[u]), cnt[u]);
        chk(u ? "b_ready" : "a_ready", int'(ro[u]), int'((q[u].size() < ST) || ifa.ready_i));
        ev = (q[u].size() > 0) ? int'(cyc - q[u][0].acc >= ST) : 0;
        chk(u ? "b_valid" : "a_valid", int'(vo[u]), ev);
        if (vo[u] && ifa.ready_i && q[u].size() > 0) begin
          e = q[u].pop_front();
          chk(u ? "b_data" : "a_data", int'(dout[u]), e.d);
        end
        if (ifa.valid_i && ro[u]) begin
          e.d = (int'(ifa.data_i) + cnt[u]) % DMOD;
          e.acc = cyc;
          q[u].push_back(e);
        end
        if (ifa.clr) cnt[u] = 0;
        else if (ifa.valid_i && ro[u])
          cnt[u] = u ? ((cnt[u] == CMAX) ? CMAX : cnt[u] + 1) : (cnt[u] + 1) % (CMAX + 1);
      end
    end
  end

  task automatic setin(bit v, int d, bit c);
    ifa.valid_i = v; ifa.data_i = DW'(d); ifa.clr = c;
    ifb.valid_i = v; ifb.data_i = DW'(d); ifb.clr = c;
  endtask

  task automatic setrdy(bit r);
    ifa.ready_i = r; ifb.ready_i = r;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    setin(0, 0, 0);
    repeat (n) step();
  endtask

  task automatic clear();
    setin(0, 0, 1); step(); setin(0, 0, 0);
  endtask

  // Present a beat and hold it until the edge that accepts it.
  task automatic send(int d, bit c);
    bit ok = 0;
    setin(1, d, c);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (ifa.ready_o) ok = 1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout t=%0t actual=stalled required=accepted", $time);
    end
    step();
  endtask

  initial begin
    setin(0, 0, 0); setrdy(1);
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_valid", int'(vo[u]), 0);
      chk("rst_ready", int'(ro[u]), 0);
      chk("rst_count", int'(cout[u]), 0);
    end
    rst_n = 1'b1;
    step();

    // back-to-back beats of 5
    repeat (3) send(5, 0);
    idle(4);
    chk("t1_count", int'(ifa.count_o), 3);

    // wrap vs saturate over 9 beats
    clear();
    repeat (9) send(0, 0);
    idle(4);
    chk("t2_count_wrap", int'(ifa.count_o), 1);
    chk("t2_count_sat", int'(ifb.count_o), CMAX);

    // stall: two beats fill the pipe, the third is held off
    clear();
    setrdy(0);
    send(1, 0);
    send(2, 0);
    setin(1, 3, 0);
    repeat (2) @(negedge clk);
    chk("t3_ready_full", int'(ifa.ready_o), 0);
    chk("t3_valid_held", int'(ifa.valid_o), 1);
    step();
    setrdy(1);
    send(3, 0);
    idle(4);

    // data wraps mod 2^DW
    clear();
    repeat (2) send(0, 0);
    send(15, 0);
    idle(4);

    // clr alongside an accepted beat uses the pre-clear count
    clear();
    repeat (5) send(0, 0);
    send(3, 1);
    send(3, 0);
    idle(4);
    chk("t5_count", int'(ifa.count_o), 1);

    // asynchronous reset with beats in flight
    clear();
    send(1, 0);
    send(2, 0);
    setin(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("mid_rst_valid", int'(vo[u]), 0);
      chk("mid_rst_ready", int'(ro[u]), 0);
      chk("mid_rst_count", int'(cout[u]), 0);
    end
    chk("mid_rst_data_b", int'(ifb.data_o), 0);
    step(); step();
    rst_n = 1'b1;
    idle(4);

    // randomized traffic with backpressure and occasional clears
    for (int i = 0; i < 400; i++) begin
      setin(1'($urandom_range(0, 1)), int'($urandom_range(0, DMOD - 1)), $urandom_range(0, 19) == 0);
      setrdy($urandom_range(0, 3) != 0);
      step();
    end
    setrdy(1);
    idle(ST + 6);
    chk("drain_a", q[0].size(), 0);
    chk("drain_b", q[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
